// File: rtl/apb_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
//   Shared types and sizing helpers for the APB memory slave.
//   - state_t   : transfer FSM states (IDLE, ACCESS)
//   - BYTES     : byte lanes per word for the default 32-bit data path
//   - IDXW      : word-index width for the default 10-bit byte address
//   - bytes_of / idxw_of : the same sizing rules for any parameterisation
// ---------------------------------------------------------------------------
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int DEF_ADDWIDTH  = 10;
    localparam int DEF_DATAWIDTH = 32;

    localparam int BYTES = DEF_DATAWIDTH / 8;
    localparam int IDXW  = DEF_ADDWIDTH - $clog2(BYTES);

    // Byte lanes in a data word of width dw.
    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    // Word-index width once the byte-offset bits are dropped from the address.
    function automatic int idxw_of(input int aw, input int dw);
        return aw - $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// ---------------------------------------------------------------------------
// apb_mem_bank
//   DEPTH x DATAWIDTH word storage with byte-enabled synchronous write and
//   combinational read from the same address.
//   Ports:
//     clk   - write clock
//     we    - write enable (commit on rising edge)
//     be    - byte-lane enables, one per 8 data bits
//     addr  - word address for both read and write
//     wdata - write data
//     rdata - combinational read data of mem[addr]
// ---------------------------------------------------------------------------
module apb_mem_bank #(
    parameter int DEPTH     = 128,
    parameter int DATAWIDTH = 32,
    parameter int AW        = 7
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DATAWIDTH/8-1:0] be,
    input  logic [AW-1:0]          addr,
    input  logic [DATAWIDTH-1:0]   wdata,
    output logic [DATAWIDTH-1:0]   rdata
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; clearing them would turn the RAM into
    // a huge flop bank, and their power-up contents are not meaningful anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATAWIDTH / 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//   APB slave fronting a word-addressed memory, with a fixed number of wait
//   states per transfer, a read-only region at the bottom of the map and an
//   error response for out-of-range indices.
//   Ports:
//     PCLK     - clock, all state on rising edge
//     PRESET   - asynchronous active-high reset
//     PSEL, PENABLE, PWRITE - APB control
//     PADDR    - byte address; bits below the word offset are ignored
//     PSTRB    - write byte lanes
//     PWDATA   - write data
//     PRDATA   - registered read data, zero except during a valid read
//     PREADY   - transfer completion (combinational)
//     PSLVERR  - error response, only ever high together with PREADY
// ---------------------------------------------------------------------------
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDWIDTH    = 10,
    parameter int DATAWIDTH   = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2,
    parameter int RO_WORDS    = 4
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDWIDTH-1:0]    PADDR,
    input  logic [DATAWIDTH/8-1:0] PSTRB,
    input  logic [DATAWIDTH-1:0]   PWDATA,
    output logic [DATAWIDTH-1:0]   PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR
);

    localparam int NBYTES = bytes_of(DATAWIDTH);
    localparam int IW     = idxw_of(ADDWIDTH, DATAWIDTH);
    localparam int OFFW   = $clog2(NBYTES);
    localparam int BAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_CYCLES);

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [DATAWIDTH-1:0] rdata_next;
    logic [DATAWIDTH-1:0] bank_rdata;
    logic [IW-1:0]        idx;
    logic [31:0]          idx_ext;
    logic                 range_err;
    logic                 ro_err;
    logic                 err;
    logic                 we;

    // Word index; the byte-offset bits only select lanes, which PSTRB does.
    assign idx     = PADDR[ADDWIDTH-1:OFFW];
    assign idx_ext = 32'(idx);

    generate
        if (OFFW > 0) begin : g_offset
            logic unused_offset;
            assign unused_offset = ^PADDR[OFFW-1:0];
        end
    endgenerate

    // Errors are judged from the address/direction presented in the current
    // cycle; the master holds them stable for the whole transfer.
    assign range_err = (idx_ext >= 32'(DEPTH));
    assign ro_err    = PWRITE && (idx_ext < 32'(RO_WORDS));
    assign err       = range_err || ro_err;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rdata_next = PRDATA;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        we         = 1'b0;

        case (state)
            IDLE: begin
                // Only a true setup phase (PSEL without PENABLE) starts a
                // transfer; a stray PENABLE here is ignored.
                if (PSEL && !PENABLE) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                    rdata_next = (!PWRITE && !err) ? bank_rdata : '0;
                end
            end

            ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: nothing is written.
                    state_next = IDLE;
                    cnt_next   = '0;
                    rdata_next = '0;
                end else if (PENABLE) begin
                    if (cnt == WAIT_MAX) begin
                        PREADY     = 1'b1;
                        PSLVERR    = err;
                        we         = PWRITE && !err;
                        state_next = IDLE;
                        cnt_next   = '0;
                        rdata_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                rdata_next = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            PRDATA <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            PRDATA <= rdata_next;
        end
    end

    apb_mem_bank #(
        .DEPTH     (DEPTH),
        .DATAWIDTH (DATAWIDTH),
        .AW        (BAW)
    ) u_bank (
        .clk   (PCLK),
        .we    (we),
        .be    (PSTRB),
        .addr  (idx[BAW-1:0]),
        .wdata (PWDATA),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//   Two instances share clock and reset: index 0 uses two wait states,
//   index 1 is the zero-wait build. A word/byte-lane array per instance holds
//   the expected memory contents; bytes never written are treated as unknown.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    logic [1:0]       psel, penable, pwrite, pready, pslverr;
    logic [1:0][9:0]  paddr;
    logic [1:0][3:0]  pstrb;
    logic [1:0][31:0] pwdata, prdata;

    int wait_of [2] = '{2, 0};

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m   [2][128];
    logic [3:0]  known_m [2][128];

    apb_mem_slave #(
        .ADDWIDTH(10), .DATAWIDTH(32), .DEPTH(128), .WAIT_CYCLES(2), .RO_WORDS(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PSTRB(pstrb[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(
        .ADDWIDTH(10), .DATAWIDTH(32), .DEPTH(128), .WAIT_CYCLES(0), .RO_WORDS(4)
    ) dut_nw (
        .PCLK(PCLK), .PRESET(PRESET),
        .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PSTRB(pstrb[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Error rule: index past the 128 stored words, or a write to words 0..3.
    function automatic bit exp_err(input bit wr, input logic [9:0] a);
        int idx;
        idx = int'(a >> 2);
        return (idx >= 128) || (wr && idx < 4);
    endfunction

    task automatic model_write(input int w, input logic [9:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        int idx;
        idx = int'(a >> 2);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                mem_m[w][idx][8*b +: 8] = d[8*b +: 8];
                known_m[w][idx][b]      = 1'b1;
            end
        end
    endtask

    // One complete APB transfer. Entered and left on a falling clock edge.
    task automatic xfer(input int w, input bit wr, input logic [9:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic [31:0] rd_first, output logic err,
                        output int waits, output bit ready);
        bit spurious;
        psel[w]    = 1'b1;
        penable[w] = 1'b0;
        pwrite[w]  = wr;
        paddr[w]   = a;
        pstrb[w]   = s;
        pwdata[w]  = d;
        @(negedge PCLK);
        penable[w] = 1'b1;
        #1;
        rd_first = prdata[w];
        rd       = '1;
        err      = 1'b0;
        waits    = 0;
        ready    = 1'b0;
        spurious = 1'b0;
        while (!ready && waits < 16) begin
            if (pready[w]) begin
                ready = 1'b1;
                rd    = prdata[w];
                err   = pslverr[w];
            end else begin
                if (pslverr[w]) spurious = 1'b1;
                @(negedge PCLK);
                #1;
                waits++;
            end
        end
        check("slverr_while_waiting", 32'(spurious), 0);
        if (ready) begin
            @(negedge PCLK);
            check("rdata_after_ready", prdata[w], 0);
            check("ready_after_ready", 32'(pready[w]), 0);
        end
        psel[w]    = 1'b0;
        penable[w] = 1'b0;
    endtask

    task automatic run_vec(input int w, input vec_t v, input bit chk_rd, input string tag);
        logic [31:0] rd, rd_first;
        logic        err;
        int          waits;
        bit          ready;
        xfer(w, v.wr, v.addr, v.strb, v.data, rd, rd_first, err, waits, ready);
        check({tag, "_ready"}, 32'(ready), 1);
        check({tag, "_waits"}, 32'(waits), 32'(wait_of[w]));
        check({tag, "_slverr"}, 32'(err), 32'(v.exp_err));
        if (chk_rd) begin
            check({tag, "_prdata"}, rd, v.exp_rd);
            check({tag, "_prdata_hold"}, rd_first, v.exp_rd);
        end
        if (v.wr && !exp_err(v.wr, v.addr)) model_write(w, v.addr, v.strb, v.data);
    endtask

    task automatic idle_drive(input int w);
        psel[w]    = 1'b0;
        penable[w] = 1'b0;
        pwrite[w]  = 1'b0;
        paddr[w]   = '0;
        pstrb[w]   = '0;
        pwdata[w]  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl  [$];
        vec_t        tbl1 [$];
        vec_t        v;
        logic [31:0] rd, rd_first, ro_val;
        logic        err;
        int          waits;
        bit          ready;

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 128; i++) begin
                mem_m[w][i]   = '0;
                known_m[w][i] = '0;
            end
        end

        PRESET = 1'b1;
        idle_drive(0);
        idle_drive(1);
        repeat (2) @(negedge PCLK);
        for (int w = 0; w < 2; w++) begin
            check("reset_pready", 32'(pready[w]), 0);
            check("reset_pslverr", 32'(pslverr[w]), 0);
            check("reset_prdata", prdata[w], 0);
        end
        PRESET = 1'b0;
        @(negedge PCLK);

        // ---------------- table vectors, two-wait instance ----------------
        tbl.push_back(vec_t'{1'b1, 10'h040, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h040, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h044, 4'hF, 32'h11223344, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h044, 4'h2, 32'hFFFFAAFF, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h044, 4'h0, 32'h0,        32'h1122AA44, 1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h200, 4'h0, 32'h0,        32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b0, 10'h3FE, 4'h0, 32'h0,        32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b1, 10'h200, 4'hF, 32'h12345678, 32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b1, 10'h00C, 4'hF, 32'h12345678, 32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b1, 10'h1FC, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h1FE, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h010, 4'hF, 32'h0BADF00D, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h013, 4'h0, 32'h0,        32'h0BADF00D, 1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h050, 4'hF, 32'h01020304, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h050, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 10'h050, 4'h0, 32'h0,        32'h01020304, 1'b0});
        tbl.push_back(vec_t'{1'b1, 10'h048, 4'hF, 32'h55667788, 32'h0,        1'b0});
        foreach (tbl[i]) run_vec(0, tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // ---------------- read-only word survives a write ----------------
        xfer(0, 1'b0, 10'h008, 4'h0, 32'h0, ro_val, rd_first, err, waits, ready);
        check("ro_read_ready", 32'(ready), 1);
        check("ro_read_slverr", 32'(err), 0);
        v = vec_t'{1'b1, 10'h008, 4'hF, ~ro_val, 32'h0, 1'b1};
        run_vec(0, v, 1'b1, "ro_write");
        xfer(0, 1'b0, 10'h008, 4'h0, 32'h0, rd, rd_first, err, waits, ready);
        check("ro_unchanged", rd, ro_val);

        // ---------------- zero-wait build, back-to-back reads ----------------
        tbl1.push_back(vec_t'{1'b1, 10'h040, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0});
        tbl1.push_back(vec_t'{1'b1, 10'h044, 4'hF, 32'h01234567, 32'h0,        1'b0});
        tbl1.push_back(vec_t'{1'b0, 10'h040, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0});
        tbl1.push_back(vec_t'{1'b0, 10'h044, 4'h0, 32'h0,        32'h01234567, 1'b0});
        tbl1.push_back(vec_t'{1'b1, 10'h004, 4'hF, 32'h0,        32'h0,        1'b1});
        foreach (tbl1[i]) run_vec(1, tbl1[i], 1'b1, $sformatf("nw%0d", i));

        // ---------------- reset in the middle of a read's wait ----------------
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 10'h040;
        @(negedge PCLK);
        penable[0] = 1'b1;
        #1;
        check("rst_read_loaded", prdata[0], 32'hDEADBEEF);
        PRESET = 1'b1;
        #1;
        check("rst_read_prdata", prdata[0], 0);
        check("rst_read_pready", 32'(pready[0]), 0);
        @(negedge PCLK);
        idle_drive(0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // ---------------- reset in the middle of a write's wait ----------------
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h048;
        pstrb[0] = 4'hF; pwdata[0] = 32'h99999999;
        @(negedge PCLK);
        penable[0] = 1'b1;
        @(negedge PCLK);
        #1;
        check("rst_write_wait_pready", 32'(pready[0]), 0);
        PRESET = 1'b1;
        #1;
        check("rst_write_pready", 32'(pready[0]), 0);
        check("rst_write_pslverr", 32'(pslverr[0]), 0);
        check("rst_write_prdata", prdata[0], 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        // Still presenting an enabled write: an IDLE slave must not respond.
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            #1;
            check("rst_idle_no_ready", 32'(pready[0]), 0);
        end
        idle_drive(0);
        @(negedge PCLK);
        run_vec(0, vec_t'{1'b0, 10'h048, 4'h0, 32'h0, 32'h55667788, 1'b0}, 1'b1, "rst_old_value");

        // ---------------- PSEL dropped during the wait ----------------
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h040;
        pstrb[0] = 4'hF; pwdata[0] = 32'h0;
        @(negedge PCLK);
        penable[0] = 1'b1;
        #1;
        check("abort_wait_pready", 32'(pready[0]), 0);
        @(negedge PCLK);
        psel[0] = 1'b0;
        #1;
        check("abort_drop_pready", 32'(pready[0]), 0);
        @(negedge PCLK);
        penable[0] = 1'b0;
        #1;
        check("abort_after_pready", 32'(pready[0]), 0);
        @(negedge PCLK);
        run_vec(0, vec_t'{1'b0, 10'h040, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0}, 1'b1, "abort_no_write");

        // ---------------- PENABLE without a setup phase ----------------
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 10'h044;
        pstrb[0] = 4'hF; pwdata[0] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("nosetup_pready", 32'(pready[0]), 0);
            check("nosetup_pslverr", 32'(pslverr[0]), 0);
            @(negedge PCLK);
        end
        idle_drive(0);
        @(negedge PCLK);
        run_vec(0, vec_t'{1'b0, 10'h044, 4'h0, 32'h0, 32'h1122AA44, 1'b0}, 1'b1, "nosetup_no_write");

        // ---------------- randomized traffic against the model ----------------
        for (int i = 0; i < 60; i++) begin
            int   w;
            int   idx;
            bit   e;
            bit   chk;
            w      = i % 2;
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(512, 1023))
                                                : 10'($urandom_range(0, 127));
            v.strb = 4'($urandom);
            v.data = $urandom;
            e      = exp_err(v.wr, v.addr);
            idx    = int'(v.addr >> 2);
            v.exp_err = e;
            v.exp_rd  = (!v.wr && !e) ? mem_m[w][idx] : 32'h0;
            chk       = v.wr || e || (known_m[w][idx] == 4'hF);
            run_vec(w, v, chk, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
